add_stream_ctrl: RTL and testbench
==================================

# add_stream_ctrl

Stream controller for the two-input add operator datapath. It watches the `a` and `b` input token streams and the output stream's backpressure, and drives the datapath's `statecase` select to fire (`1`) or stall (`0`). It captures the datapath's combinational sum into a 2-entry output queue and handles end-of-stream (EOS) tokens. It sits between the operator's stream FIFOs and its `_dp` datapath module, replacing a trivial always-fire FSM.

## Interface
Parameters:
- `W`, default 16: datapath/sum width.
- `CNT_W`, default 16: fire counter width.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `a_v`, in, 1: token present on stream `a`.
- `a_eos`, in, 1: present `a` token is EOS. Qualified by `a_v`.
- `a_r`, out, 1: pop `a` this cycle.
- `b_v`, in, 1: token present on stream `b`.
- `b_eos`, in, 1: present `b` token is EOS. Qualified by `b_v`.
- `b_r`, out, 1: pop `b` this cycle.
- `statecase`, out, 1: to datapath. `0` = stall, `1` = fire.
- `dp_sum`, in, W: datapath result `(a_d + b_d)`, valid while `statecase=1`.
- `o_d`, out, W: output queue head data.
- `o_eos`, out, 1: queue head is EOS.
- `o_v`, out, 1: queue non-empty.
- `o_b`, in, 1: downstream backpressure. `1` = cannot accept.
- `fire_cnt`, out, CNT_W: number of fires since reset, saturating.
- `len_err`, out, 1: sticky; the streams ended at different lengths.
- `done`, out, 1: EOS has been delivered downstream.

## Operation
- The queue holds 2 entries of `{eos, data[W-1:0]}` plus a 2-bit count (0..2).
- `o_v = (count != 0)`.
- Dequeue occurs when `o_v & !o_b`.
- `space = (count < 2) | (o_v & !o_b)`. Enqueue and dequeue may occur in the same cycle; count is then unchanged.
- The FSM has states RUN (0), DRAIN (1), DONE (2). Encoding 3 is illegal and returns to RUN.
- RUN, evaluated each cycle with priority in this order:
  - **fire:** `a_v & b_v & !a_eos & !b_eos & space`. Drive `statecase=1`, `a_r=1`, `b_r=1`; enqueue `{0, dp_sum}`; `fire_cnt` += 1, saturating at all-ones.
  - **joint EOS:** `a_v & a_eos & b_v & b_eos & space`. Pop both, enqueue `{1, 0}`, go to DRAIN. `statecase=0`.
  - **length mismatch:** one side shows EOS and the other shows a data token. Pop and discard the data token only (the EOS side is held), `statecase=0`, set `len_err`. Repeat until both sides show EOS.
  - **otherwise:** all outputs idle (`statecase=0`, `a_r=b_r=0`).
- DRAIN:
  - No pops, `statecase=0`.
  - Go to DONE in the cycle the EOS entry is dequeued (head `eos=1` & `!o_b`).
- DONE:
  - `done=1`.
  - `a_r`, `b_r`, `statecase` stay 0; the queue stays empty.
  - Remains in DONE until `reset`.
- `a_r`/`b_r` are never asserted without the matching `_v`.
- `fire_cnt` and `len_err` hold their values in DRAIN and DONE.

## Timing
- Reset values (cycle after `reset` is sampled high): state RUN, count 0, `o_v=0`, `o_eos=0`, `o_d=0`, `fire_cnt=0`, `len_err=0`, `done=0`.
- `a_r`, `b_r`, `statecase` are combinational from current inputs and state. They are 0 while `reset=1`.
- Reset mid-stream discards queued tokens immediately. No EOS is emitted.
- Fire-to-output latency is 1 cycle: the sum appears on `o_d` with `o_v=1` the cycle after the fire when the queue was empty.
- Throughput is 1 fire per cycle with `o_b=0` sustained.
- With `o_b=1`: at most 2 fires proceed, then `statecase=0` until a dequeue.
- With count=2 and `o_b=0` in the same cycle, the fire still proceeds (pass-through space).
- `done` rises the cycle after the EOS handshake (`o_v & o_eos & !o_b`).
- Sum width is W. The carry-out is dropped by the datapath; no overflow flag.

## Test plan
- **Fire and latency.** Reset, then `a_v=b_v=1` with data 3 and 4, `dp_sum=7`, `o_b=0` for 1 cycle → `statecase=1`, `a_r=b_r=1`; next cycle `o_v=1`, `o_d=7`; `fire_cnt=1`.
- **Backpressure.** Hold `o_b=1` and both inputs valid for 5 cycles → exactly 2 fires, count=2, then `statecase=0`. Release `o_b` → one dequeue per cycle and resumed fires in the same cycles.
- **Clean EOS.** 3 data pairs followed by EOS on both, `o_b=0` → `o_d` sequence is sums 1..3, then `o_eos=1`, then `done=1` one cycle later. `len_err=0`, `fire_cnt=3`.
- **Length mismatch.** `a` is EOS while `b` holds 2 data tokens then EOS → the 2 `b` tokens are popped with `statecase=0` and `a_r=0`; `len_err=1`; EOS is then emitted and `done=1`.
- **Saturation.** `CNT_W=4`, 20 fires → `fire_cnt` stops at 15.
- **Reset mid-operation.** Assert `reset` with count=2 in DRAIN → next cycle `o_v=0`, state RUN, `fire_cnt=0`, `done=0`; a subsequent fire works normally.

Source files
------------

// File: rtl/add_stream_ctrl.sv
// add_stream_ctrl: joins the a/b token streams into the add datapath.
// Fires the datapath when both sides hold data and the output has room,
// buffers sums in a 2-entry queue, and sequences end-of-stream handling.
module add_stream_ctrl #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_v,
  input  logic             a_eos,
  output logic             a_r,
  input  logic             b_v,
  input  logic             b_eos,
  output logic             b_r,
  output logic             statecase,
  input  logic [W-1:0]     dp_sum,
  output logic [W-1:0]     o_d,
  output logic             o_eos,
  output logic             o_v,
  input  logic             o_b,
  output logic [CNT_W-1:0] fire_cnt,
  output logic             len_err,
  output logic             done
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [W:0]       ent0_q, ent0_d;
  logic [W:0]       ent1_q, ent1_d;
  logic [CNT_W-1:0] fire_cnt_q, fire_cnt_d;
  logic             len_err_q, len_err_d;
  logic             done_q, done_d;

  logic             deq;
  logic             space;
  logic             enq;
  logic [W:0]       enq_val;

  // Entry 0 is always the queue head; an empty queue shows zeros.
  assign o_v      = (count_q != 2'd0);
  assign o_d      = o_v ? ent0_q[W-1:0] : '0;
  assign o_eos    = o_v & ent0_q[W];
  assign deq      = o_v & ~o_b;
  assign space    = (count_q < 2'd2) | deq;
  assign fire_cnt = fire_cnt_q;
  assign len_err  = len_err_q;
  assign done     = done_q;

  // Handshake decisions for this cycle plus next-state of the FSM and queue.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    fire_cnt_d = fire_cnt_q;
    len_err_d  = len_err_q;
    a_r        = 1'b0;
    b_r        = 1'b0;
    statecase  = 1'b0;
    enq        = 1'b0;
    enq_val    = '0;

    case (state_q)
      RUN: begin
        if (!reset) begin
          if (a_v && b_v && !a_eos && !b_eos && space) begin
            statecase = 1'b1;
            a_r       = 1'b1;
            b_r       = 1'b1;
            enq       = 1'b1;
            enq_val   = {1'b0, dp_sum};
            if (fire_cnt_q != {CNT_W{1'b1}}) fire_cnt_d = fire_cnt_q + CNT_W'(1);
          end else if (a_v && a_eos && b_v && b_eos && space) begin
            a_r     = 1'b1;
            b_r     = 1'b1;
            enq     = 1'b1;
            enq_val = {1'b1, {W{1'b0}}};
            state_d = DRAIN;
          end else if (a_v && a_eos && b_v && !b_eos) begin
            b_r       = 1'b1;
            len_err_d = 1'b1;
          end else if (b_v && b_eos && a_v && !a_eos) begin
            a_r       = 1'b1;
            len_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (deq && ent0_q[W]) state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    case ({enq, deq})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = enq_val;
        else                 ent1_d = enq_val;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = enq_val;
        end else begin
          ent0_d = ent1_q;
          ent1_d = enq_val;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase

    done_d = (state_d == DONE);
  end

  // State register with synchronous reset; reset drops any queued tokens.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      count_q    <= 2'd0;
      ent0_q     <= '0;
      ent1_q     <= '0;
      fire_cnt_q <= '0;
      len_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      fire_cnt_q <= fire_cnt_d;
      len_err_q  <= len_err_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_add_stream_ctrl.sv
// tb_add_stream_ctrl: scenario tasks plus randomized streams checked
// against a queue-based reference model of the stream controller.
module tb_add_stream_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             clock;
  logic             reset;
  logic             a_v, a_eos, a_r;
  logic             b_v, b_eos, b_r;
  logic             statecase;
  logic [W-1:0]     dp_sum;
  logic [W-1:0]     o_d;
  logic             o_eos, o_v, o_b;
  logic [CNT_W-1:0] fire_cnt;
  logic             len_err, done;

  int checks;
  int failures;

  // Stream sources: tokens 0..len-1 are data, token len is EOS.
  int a_len, b_len, a_idx, b_idx;

  // Reference model state.
  logic [W:0] exp_q[$];
  int         m_phase;
  int         m_fire;
  bit         m_err;
  bit         exp_sc, exp_ar, exp_br;
  bit         m_deq, m_enq, m_fire_ev, m_err_ev, m_eos_ev;
  logic [W:0] m_enq_val;

  add_stream_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .a_v(a_v), .a_eos(a_eos), .a_r(a_r),
    .b_v(b_v), .b_eos(b_eos), .b_r(b_r),
    .statecase(statecase), .dp_sum(dp_sum),
    .o_d(o_d), .o_eos(o_eos), .o_v(o_v), .o_b(o_b),
    .fire_cnt(fire_cnt), .len_err(len_err), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decide what the controller should do with the current inputs.
  function automatic void model_comb();
    int n;
    bit ov, space;
    n = exp_q.size();
    ov = (n != 0);
    exp_sc = 0; exp_ar = 0; exp_br = 0;
    m_enq = 0; m_enq_val = '0; m_fire_ev = 0; m_err_ev = 0; m_eos_ev = 0;
    m_deq = ov && !o_b;
    space = (n < 2) || m_deq;
    if (reset) begin
      m_deq = 0;
      return;
    end
    if (m_phase == 0) begin
      if (a_v && b_v && !a_eos && !b_eos && space) begin
        exp_sc = 1; exp_ar = 1; exp_br = 1;
        m_enq = 1; m_enq_val = {1'b0, dp_sum}; m_fire_ev = 1;
      end else if (a_v && a_eos && b_v && b_eos && space) begin
        exp_ar = 1; exp_br = 1;
        m_enq = 1; m_enq_val = {1'b1, {W{1'b0}}}; m_eos_ev = 1;
      end else if (a_v && a_eos && b_v && !b_eos) begin
        exp_br = 1; m_err_ev = 1;
      end else if (b_v && b_eos && a_v && !a_eos) begin
        exp_ar = 1; m_err_ev = 1;
      end
    end
  endfunction

  // Apply the decided actions at the clock edge.
  function automatic void model_clock();
    bit head_eos;
    logic [W:0] tmp;
    if (reset) begin
      exp_q.delete();
      m_phase = 0; m_fire = 0; m_err = 0;
      return;
    end
    head_eos = (exp_q.size() > 0) ? exp_q[0][W] : 1'b0;
    if (m_deq) tmp = exp_q.pop_front();
    if (m_enq) exp_q.push_back(m_enq_val);
    if (m_fire_ev && m_fire < SAT) m_fire++;
    if (m_err_ev) m_err = 1;
    if (m_phase == 0 && m_eos_ev) m_phase = 1;
    else if (m_phase == 1 && m_deq && head_eos) m_phase = 2;
  endfunction

  task automatic start_streams(input int la, input int lb);
    a_len = la; b_len = lb; a_idx = 0; b_idx = 0;
  endtask

  task automatic drive_inputs(input int pa, input int pb, input int pob);
    a_v    = (a_idx <= a_len) && (int'($urandom_range(99)) < pa);
    a_eos  = (a_idx == a_len);
    b_v    = (b_idx <= b_len) && (int'($urandom_range(99)) < pb);
    b_eos  = (b_idx == b_len);
    o_b    = (int'($urandom_range(99)) < pob);
    dp_sum = W'($urandom);
  endtask

  // Settle the model for this cycle and move to the sampling edge.
  task automatic prep();
    model_comb();
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    model_clock();
    if (exp_ar) a_idx++;
    if (exp_br) b_idx++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_v = 0; a_eos = 0; b_v = 0; b_eos = 0; o_b = 0; dp_sum = '0;
    prep();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_v = 1; a_eos = 0; b_v = 1; b_eos = 0; o_b = 0; dp_sum = 8'h11;
    prep();
    checks++;
    if ({statecase, a_r, b_r} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_handshake: got %b expected 000", {statecase, a_r, b_r});
    end
    tick();
    @(negedge clock);
    checks++;
    if ({o_v, o_eos, o_d} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_queue: got o_v=%b o_eos=%b o_d=%0h expected 0 0 0", o_v, o_eos, o_d);
    end
    checks++;
    if ({fire_cnt, len_err, done} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_status: got cnt=%0d err=%b done=%b expected 0 0 0", fire_cnt, len_err, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_fire_latency();
    do_reset();
    start_streams(1, 1);
    drive_inputs(100, 100, 0);
    dp_sum = 8'd7;
    prep();
    checks++;
    if ({statecase, a_r, b_r} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL fire_handshake: got %b expected 111", {statecase, a_r, b_r});
    end
    tick();
    a_v = 0; b_v = 0;
    prep();
    checks++;
    if ({o_v, o_eos, o_d, fire_cnt} !== {1'b1, 1'b0, 8'd7, 4'd1}) begin
      failures++;
      $display("[TB] FAIL fire_latency: got o_v=%b o_eos=%b o_d=%0d cnt=%0d expected 1 0 7 1", o_v, o_eos, o_d, fire_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int fires;
    do_reset();
    start_streams(20, 20);
    fires = 0;
    for (int i = 0; i < 5; i++) begin
      drive_inputs(100, 100, 100);
      prep();
      if (statecase === 1'b1) fires++;
      checks++;
      if (statecase !== exp_sc) begin
        failures++;
        $display("[TB] FAIL bp_stall cycle %0d: got %b expected %b", i, statecase, exp_sc);
      end
      tick();
    end
    checks++;
    if (fires !== 2 || o_v !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_fire_count: got fires=%0d o_v=%b expected 2 1", fires, o_v);
    end
    for (int i = 0; i < 3; i++) begin
      drive_inputs(100, 100, 0);
      prep();
      checks++;
      if (statecase !== 1'b1 || o_v !== 1'b1 || o_d !== exp_q[0][W-1:0]) begin
        failures++;
        $display("[TB] FAIL bp_release cycle %0d: got sc=%b o_v=%b o_d=%0h expected 1 1 %0h", i, statecase, o_v, o_d, exp_q[0][W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_clean_eos();
    logic [W:0] seen[$];
    bit hs_prev, hs;
    do_reset();
    start_streams(3, 3);
    hs_prev = 0;
    for (int i = 0; i < 12; i++) begin
      drive_inputs(100, 100, 0);
      dp_sum = W'(b_idx + 1);
      prep();
      hs = o_v && o_eos && !o_b;
      if (o_v && !o_b) seen.push_back({o_eos, o_d});
      checks++;
      if ({statecase, a_r, b_r} !== {exp_sc, exp_ar, exp_br}) begin
        failures++;
        $display("[TB] FAIL eos_handshake cycle %0d: got %b expected %b", i, {statecase, a_r, b_r}, {exp_sc, exp_ar, exp_br});
      end
      if (hs_prev || hs) begin
        checks++;
        if (done !== hs_prev) begin
          failures++;
          $display("[TB] FAIL eos_done_timing cycle %0d: got done=%b expected %b", i, done, hs_prev);
        end
      end
      hs_prev = hs;
      tick();
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 9'h001 || seen[1] !== 9'h002 || seen[2] !== 9'h003 || seen[3] !== 9'h100) begin
      failures++;
      $display("[TB] FAIL eos_sequence: got %0d entries expected 4 (1,2,3,EOS)", seen.size());
    end
    checks++;
    if ({done, len_err, fire_cnt} !== {1'b1, 1'b0, 4'd3}) begin
      failures++;
      $display("[TB] FAIL eos_final: got done=%b err=%b cnt=%0d expected 1 0 3", done, len_err, fire_cnt);
    end
  endtask

  task automatic test_len_mismatch();
    do_reset();
    start_streams(0, 2);
    for (int i = 0; i < 2; i++) begin
      drive_inputs(100, 100, 0);
      prep();
      checks++;
      if ({statecase, a_r, b_r} !== 3'b001) begin
        failures++;
        $display("[TB] FAIL mismatch_pop cycle %0d: got %b expected 001", i, {statecase, a_r, b_r});
      end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive_inputs(100, 100, 0);
      prep();
      tick();
    end
    @(negedge clock);
    checks++;
    if ({len_err, done, fire_cnt} !== {1'b1, 1'b1, 4'd0}) begin
      failures++;
      $display("[TB] FAIL mismatch_final: got err=%b done=%b cnt=%0d expected 1 1 0", len_err, done, fire_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    start_streams(25, 25);
    for (int i = 0; i < 20; i++) begin
      drive_inputs(100, 100, 0);
      prep();
      checks++;
      if (int'(fire_cnt) !== ((i < SAT) ? i : SAT) || statecase !== 1'b1) begin
        failures++;
        $display("[TB] FAIL saturation cycle %0d: got cnt=%0d sc=%b expected %0d 1", i, fire_cnt, statecase, (i < SAT) ? i : SAT);
      end
      tick();
    end
    @(negedge clock);
    checks++;
    if (fire_cnt !== 4'd15) begin
      failures++;
      $display("[TB] FAIL saturation_final: got %0d expected 15", fire_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_streams(1, 1);
    for (int i = 0; i < 2; i++) begin
      drive_inputs(100, 100, 100);
      prep();
      tick();
    end
    @(negedge clock);
    checks++;
    if (o_v !== 1'b1 || done !== 1'b0 || exp_q.size() != 2) begin
      failures++;
      $display("[TB] FAIL mid_setup: got o_v=%b done=%b expected 1 0", o_v, done);
    end
    reset = 1'b1;
    a_v = 1; a_eos = 0; b_v = 1; b_eos = 0; o_b = 0;
    prep();
    checks++;
    if ({statecase, a_r, b_r} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL mid_reset_handshake: got %b expected 000", {statecase, a_r, b_r});
    end
    tick();
    reset = 1'b0;
    start_streams(1, 1);
    drive_inputs(100, 100, 0);
    dp_sum = 8'h5A;
    prep();
    checks++;
    if ({o_v, fire_cnt, done, len_err} !== '0 || statecase !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_after_reset: got o_v=%b cnt=%0d done=%b sc=%b expected 0 0 0 1", o_v, fire_cnt, done, statecase);
    end
    tick();
    a_v = 0; b_v = 0;
    prep();
    checks++;
    if ({o_v, o_d, fire_cnt} !== {1'b1, 8'h5A, 4'd1}) begin
      failures++;
      $display("[TB] FAIL mid_refire: got o_v=%b o_d=%0h cnt=%0d expected 1 5a 1", o_v, o_d, fire_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    int cyc, tail;
    for (int run = 0; run < 6; run++) begin
      do_reset();
      start_streams(int'($urandom_range(12)), int'($urandom_range(12)));
      cyc = 0;
      tail = 0;
      while (tail < 3 && cyc < 300) begin
        drive_inputs(70, 70, 30);
        prep();
        checks++;
        if ({statecase, a_r, b_r} !== {exp_sc, exp_ar, exp_br}) begin
          failures++;
          $display("[TB] FAIL rand_handshake run %0d cycle %0d: got %b expected %b", run, cyc, {statecase, a_r, b_r}, {exp_sc, exp_ar, exp_br});
        end
        checks++;
        if ({o_v, done, len_err, fire_cnt} !== {exp_q.size() != 0, m_phase == 2, m_err, 4'(m_fire)}) begin
          failures++;
          $display("[TB] FAIL rand_status run %0d cycle %0d: got o_v=%b done=%b err=%b cnt=%0d expected %b %b %b %0d",
                   run, cyc, o_v, done, len_err, fire_cnt, exp_q.size() != 0, m_phase == 2, m_err, m_fire);
        end
        if (exp_q.size() != 0) begin
          checks++;
          if ({o_eos, o_d} !== exp_q[0]) begin
            failures++;
            $display("[TB] FAIL rand_head run %0d cycle %0d: got %0h expected %0h", run, cyc, {o_eos, o_d}, exp_q[0]);
          end
        end
        if (m_phase == 2) tail++;
        tick();
        cyc++;
      end
      if (tail < 3) begin
        checks++;
        failures++;
        $display("[TB] FAIL rand_timeout run %0d: stream did not finish in 300 cycles", run);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    a_len = 0; b_len = 0; a_idx = 0; b_idx = 0;
    m_phase = 0; m_fire = 0; m_err = 0;
    test_reset();
    test_fire_latency();
    test_backpressure();
    test_clean_eos();
    test_len_mismatch();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
